run_sequencer: RTL
==================

Name: run_sequencer

Overview:
- Run-level controller for the single-cycle 9-bit-instruction core.
- Owns the Start/Ack handshake with the bench and holds the core in init while Start is high.
- On Start release, loads the PC with the selected program's base address and gates core execution.
- Counts executed cycles, detects core halt or watchdog expiry, and reports done.

Parameters:
PC_W, 10, program counter / InstROM address width
CNT_W, 16, cycle counter width
INIT_CYCLES, 2, cycles the core is held in init after Start falls (>=1)
TIMEOUT, 16'hFFFF, watchdog limit on CycleCt in RUN
PROG0_BASE, 10'd0, base address for ProgSel=0
PROG1_BASE, 10'd256, base address for ProgSel=1
PROG2_BASE, 10'd512, base address for ProgSel=2
PROG3_BASE, 10'd768, base address for ProgSel=3

Ports:
Clk  input  1  clock, posedge only
Reset  input  1  asynchronous, active-low reset
Start  input  1  bench start request, level; program launches on its falling edge
ProgSel  input  2  program select, sampled on the ARM->INIT transition
Halt  input  1  core halt flag from the control decoder, level
CoreInit  output  1  holds core state (PC, register file) in init
CoreEn  output  1  core may advance PC and commit writes this cycle
PCLoad  output  1  one-cycle strobe: PC <= PCLoadAddr
PCLoadAddr  output  PC_W  selected program base address
Ack  output  1  run finished, held until next Start
Timeout  output  1  last run ended by the watchdog
CycleCt  output  CNT_W  cycles spent in RUN for the current or last run

Behaviour:
- Reset low, asynchronous:
  - state = IDLE.
  - CoreInit = 1; CoreEn, PCLoad, Ack, Timeout = 0.
  - CycleCt = 0; PCLoadAddr = PROG0_BASE; internal init counter = 0.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: CoreInit=1. Start=1 -> ARM.
  - ARM: CoreInit=1; Ack and Timeout cleared on entry; CycleCt cleared.
    - Start=0 -> INIT; latch ProgSel and drive PCLoadAddr from the base table.
  - INIT: CoreInit=1 for exactly INIT_CYCLES cycles, then -> LOAD.
    - Start=1 during INIT -> ARM (restart; ProgSel resampled at next release).
  - LOAD: CoreInit=0, PCLoad=1 for exactly one cycle, CoreEn=0 -> RUN.
  - RUN: CoreEn=1; CycleCt += 1 every cycle.
    - Halt=1 -> DONE. CycleCt excludes the halting cycle. Ack=1 from the first DONE cycle.
    - CycleCt == TIMEOUT-1 with Halt=0 -> DONE with Timeout=1. CycleCt saturates at TIMEOUT.
    - Halt and the timeout limit in the same cycle: Halt wins, Timeout=0.
    - Start=1 in RUN is ignored; the run completes first.
  - DONE: CoreEn=0, CoreInit=0 (core state preserved for bench inspection).
    - Ack, Timeout and CycleCt hold. Start=1 -> ARM.
- Latency:
  - Start falling edge to PCLoad = INIT_CYCLES+1 cycles.
  - PCLoad to first CoreEn = 1 cycle.
  - Halt to Ack = 1 cycle.
- CycleCt never wraps and never exceeds TIMEOUT.
- Halt seen outside RUN is ignored.
- Reset asserted mid-run immediately forces the reset values above; no partial Ack.

Optional Feature:
- Macro: RUN_SEQUENCER_STEP_EN.
- With the macro defined:
  - Two extra inputs: StepMode (1 bit) and Step (1 bit).
  - In RUN with StepMode=1, CoreEn pulses high for one cycle per Step rising edge, detected by a registered edge detect.
  - CycleCt increments only on cycles with CoreEn=1.
  - The watchdog counts only enabled cycles.
  - Halt is honoured only on a CoreEn=1 cycle.
- Without the macro: the ports are absent and RUN is free-running as specified.

Test Plan:
- Reset low mid-RUN after 5 cycles -> next edge: CoreInit=1, CoreEn=0, Ack=0, CycleCt=0, state IDLE. Reset high, then Start pulse -> normal run.
- Start=1 for 3 cycles, ProgSel=2, Start=0 -> PCLoad=1 with PCLoadAddr=512 exactly 3 cycles after release (INIT_CYCLES=2). CoreEn rises the next cycle.
- RUN, Halt asserted after 40 enabled cycles -> Ack=1 next cycle, CycleCt=40, Timeout=0. Ack stays high 10 idle cycles; Start=1 clears Ack.
- TIMEOUT=100, Halt never asserted -> DONE with Timeout=1, Ack=1, CycleCt=100, CoreEn=0.
- TIMEOUT=100, Halt asserted on the cycle CycleCt=99 -> Ack=1, Timeout=0.
- Start re-asserted during INIT with ProgSel changed 1->3 at release -> PCLoadAddr=768, single PCLoad pulse. Start=1 during RUN -> no effect.

Source files
------------

// File: rtl/run_sequencer.sv
// Run-level controller: Start/Ack handshake, program launch, cycle count and watchdog.
// Optional single-step gating of CoreEn is enabled by defining RUN_SEQUENCER_STEP_EN.
module run_sequencer #(
   parameter int unsigned      PC_W        = 10,
   parameter int unsigned      CNT_W       = 16,
   parameter int unsigned      INIT_CYCLES = 2,
   parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF,
   parameter logic [PC_W-1:0]  PROG0_BASE  = 10'd0,
   parameter logic [PC_W-1:0]  PROG1_BASE  = 10'd256,
   parameter logic [PC_W-1:0]  PROG2_BASE  = 10'd512,
   parameter logic [PC_W-1:0]  PROG3_BASE  = 10'd768
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       ProgSel,
   input  logic             Halt,
`ifdef RUN_SEQUENCER_STEP_EN
   input  logic             StepMode,
   input  logic             Step,
`endif
   output logic             CoreInit,
   output logic             CoreEn,
   output logic             PCLoad,
   output logic [PC_W-1:0]  PCLoadAddr,
   output logic             Ack,
   output logic             Timeout,
   output logic [CNT_W-1:0] CycleCt
);

   localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ARM, INIT, LOAD, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
   logic              core_init_q, core_init_d;
   logic              core_en_q, core_en_d;
   logic              pc_load_q, pc_load_d;
   logic [PC_W-1:0]   pc_addr_q, pc_addr_d;
   logic              ack_q, ack_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic              en_req;

`ifdef RUN_SEQUENCER_STEP_EN
   logic step_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) step_q <= 1'b0;
      else        step_q <= Step;
   end

   assign en_req = !StepMode || (Step && !step_q);
`else
   assign en_req = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      pc_addr_d  = pc_addr_q;
      ack_d      = ack_q;
      timeout_d  = timeout_q;
      cyc_d      = cyc_q;

      case (state_q)
         IDLE: if (Start) state_d = ARM;
         ARM: begin
            if (!Start) begin
               state_d    = INIT;
               init_cnt_d = '0;
               case (ProgSel)
                  2'd0:    pc_addr_d = PROG0_BASE;
                  2'd1:    pc_addr_d = PROG1_BASE;
                  2'd2:    pc_addr_d = PROG2_BASE;
                  default: pc_addr_d = PROG3_BASE;
               endcase
            end
         end
         INIT: begin
            if (Start)                        state_d = ARM;
            else if (init_cnt_q == INIT_LAST) state_d = LOAD;
            else                              init_cnt_d = init_cnt_q + 1'b1;
         end
         LOAD: state_d = RUN;
         RUN: begin
            // Only enabled cycles count or honour Halt; Halt beats the watchdog.
            if (core_en_q) begin
               if (Halt) begin
                  state_d = DONE;
                  ack_d   = 1'b1;
               end else if (cyc_q == TIMEOUT - 1'b1) begin
                  state_d   = DONE;
                  ack_d     = 1'b1;
                  timeout_d = 1'b1;
                  cyc_d     = TIMEOUT;
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
         end
         DONE: if (Start) state_d = ARM;
         default: state_d = IDLE;
      endcase

      if (state_d == ARM) begin
         ack_d     = 1'b0;
         timeout_d = 1'b0;
         cyc_d     = '0;
      end

      core_init_d = (state_d == IDLE) || (state_d == ARM) || (state_d == INIT);
      pc_load_d   = (state_d == LOAD);
      core_en_d   = (state_d == RUN) && en_req;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         init_cnt_q  <= '0;
         core_init_q <= 1'b1;
         core_en_q   <= 1'b0;
         pc_load_q   <= 1'b0;
         pc_addr_q   <= PROG0_BASE;
         ack_q       <= 1'b0;
         timeout_q   <= 1'b0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         core_init_q <= core_init_d;
         core_en_q   <= core_en_d;
         pc_load_q   <= pc_load_d;
         pc_addr_q   <= pc_addr_d;
         ack_q       <= ack_d;
         timeout_q   <= timeout_d;
         cyc_q       <= cyc_d;
      end
   end

   assign CoreInit   = core_init_q;
   assign CoreEn     = core_en_q;
   assign PCLoad     = pc_load_q;
   assign PCLoadAddr = pc_addr_q;
   assign Ack        = ack_q;
   assign Timeout    = timeout_q;
   assign CycleCt    = cyc_q;

endmodule
